// File: rtl/mux_scan_if.sv
// Bundle of the signals between the scan sequencer, the 16:1 mux it drives and
// the consumer of assembled words. The sequencer uses the master view.
interface mux_scan_if;
    logic        start;
    logic        continuous;
    logic        mux_o;
    logic        ready;
    logic [3:0]  sel;
    logic [15:0] data;
    logic        valid;
    logic        busy;
    logic        overrun;

    modport master (
        input  start, continuous, mux_o, ready,
        output sel, data, valid, busy, overrun
    );

    modport slave (
        output start, continuous, mux_o, ready,
        input  sel, data, valid, busy, overrun
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 16:1 mux: steps sel through all channels, holds each one
// for SETTLE_CYC+2 cycles, samples mux_o on the last cycle and publishes the
// assembled 16-bit word through a valid/ready handshake. All outputs are flops.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_scan_if.master bus
);

    localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic        complete_s;

    // Next-state, channel stepping, word assembly and handshake bookkeeping.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overrun_d  = 1'b0;
        complete_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sel_d = 4'd0;
                cnt_d = 4'd0;
                if (bus.start) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LIM) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                shift_d[sel_q] = bus.mux_o;
                cnt_d          = 4'd0;
                if (sel_q == 4'd15) begin
                    // Last channel: publish the word including this edge's bit,
                    // and clear the assembly register for the next scan.
                    complete_s = 1'b1;
                    data_d     = {bus.mux_o, shift_q[14:0]};
                    shift_d    = 16'h0000;
                    sel_d      = 4'd0;
                    if (bus.continuous) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    sel_d   = sel_q + 4'd1;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 4'd0;
                cnt_d   = 4'd0;
            end
        endcase

        // A completing word always wins over a consume on the same edge.
        if (complete_s) begin
            valid_d   = 1'b1;
            overrun_d = valid_q & ~bus.ready;
        end else if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any partially assembled word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= 4'd0;
            cnt_q     <= 4'd0;
            shift_q   <= 16'h0000;
            data_q    <= 16'h0000;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.data    = data_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with SETTLE_CYC=0 and one with
// SETTLE_CYC=2, each fed by a modelled mux (mux_o = in[sel]).
module tb_mux_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] in0;
    logic [15:0] in2;
    int          pass_cnt;
    int          total_cnt;

    mux_scan_if if0 ();
    mux_scan_if if2 ();

    assign if0.mux_o = in0[if0.sel];
    assign if2.mux_o = in2[if2.sel];

    mux_scan_ctrl #(.SETTLE_CYC(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mux_scan_ctrl #(.SETTLE_CYC(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        in0 = 16'h0000;
        in2 = 16'h0000;
        if0.start = 1'b0; if0.continuous = 1'b0; if0.ready = 1'b0;
        if2.start = 1'b0; if2.continuous = 1'b0; if2.ready = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_sel",   {28'd0, if0.sel}, 32'd0);
        chk("rst_data",  {16'd0, if0.data}, 32'd0);
        chk("rst_valid", {31'd0, if0.valid}, 32'd0);
        chk("rst_busy",  {31'd0, if0.busy}, 32'd0);
        chk("rst_ovr",   {31'd0, if0.overrun}, 32'd0);
        chk("rst2_data", {16'd0, if2.data}, 32'd0);
        #3 rst_n = 1'b1;
        tick();

        // Single scan, SETTLE_CYC=0, in=A5C3
        in0 = 16'hA5C3;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        chk("s0_busy_start", {31'd0, if0.busy}, 32'd1);
        for (int j = 0; j < 32; j++) begin
            chk("s0_sel", {28'd0, if0.sel}, 32'(j / 2));
            if (j == 31) chk("s0_valid_early", {31'd0, if0.valid}, 32'd0);
            tick();
        end
        chk("s0_valid", {31'd0, if0.valid}, 32'd1);
        chk("s0_data",  {16'd0, if0.data}, 32'h0000A5C3);
        chk("s0_busy_end", {31'd0, if0.busy}, 32'd0);
        chk("s0_ovr",   {31'd0, if0.overrun}, 32'd0);

        // Consume one cycle later: valid drops, data retained
        if0.ready = 1'b1;
        tick();
        if0.ready = 1'b0;
        chk("hs_late_valid", {31'd0, if0.valid}, 32'd0);
        chk("hs_late_data",  {16'd0, if0.data}, 32'h0000A5C3);

        // Single scan, SETTLE_CYC=2, in=8001 with a glitch on channel 5's settle cycles
        in2 = 16'h8001;
        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        for (int j = 0; j < 64; j++) begin
            chk("s2_sel", {28'd0, if2.sel}, 32'(j / 4));
            if (j == 20) in2 = 16'h8021;
            if (j == 23) in2 = 16'h8001;
            if (j == 63) chk("s2_valid_early", {31'd0, if2.valid}, 32'd0);
            tick();
        end
        chk("s2_valid", {31'd0, if2.valid}, 32'd1);
        chk("s2_data",  {16'd0, if2.data}, 32'h00008001);
        chk("s2_busy_end", {31'd0, if2.busy}, 32'd0);

        // Continuous mode, ready held 0
        in0 = 16'h0F0F;
        if0.continuous = 1'b1;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        for (int j = 0; j < 64; j++) begin
            chk("c_busy", {31'd0, if0.busy}, 32'd1);
            if (j == 30) in0 = 16'h1234;
            if (j == 32) begin
                chk("c_w1_data",  {16'd0, if0.data}, 32'h00000F0F);
                chk("c_w1_valid", {31'd0, if0.valid}, 32'd1);
                chk("c_w1_ovr",   {31'd0, if0.overrun}, 32'd0);
            end
            tick();
        end
        chk("c_w2_ovr",   {31'd0, if0.overrun}, 32'd1);
        chk("c_w2_valid", {31'd0, if0.valid}, 32'd1);
        chk("c_w2_data",  {16'd0, if0.data}, 32'h00001234);
        chk("c_w2_busy",  {31'd0, if0.busy}, 32'd1);
        tick();
        chk("c_ovr_pulse", {31'd0, if0.overrun}, 32'd0);
        chk("c_valid_hold", {31'd0, if0.valid}, 32'd1);
        chk("c_busy2", {31'd0, if0.busy}, 32'd1);
        in0 = 16'hBEEF;

        // Ready asserted on the completion edge of the third word
        repeat (30) tick();
        if0.ready = 1'b1;
        tick();
        chk("hs_same_ovr",   {31'd0, if0.overrun}, 32'd0);
        chk("hs_same_valid", {31'd0, if0.valid}, 32'd1);
        chk("hs_same_data",  {16'd0, if0.data}, 32'h0000BEEF);
        tick();
        if0.ready = 1'b0;
        chk("hs_next_valid", {31'd0, if0.valid}, 32'd0);
        chk("hs_next_data",  {16'd0, if0.data}, 32'h0000BEEF);

        // Asynchronous reset at channel 7 of the fourth scan
        repeat (13) tick();
        chk("ar_sel7", {28'd0, if0.sel}, 32'd7);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_sel",   {28'd0, if0.sel}, 32'd0);
        chk("ar_data",  {16'd0, if0.data}, 32'd0);
        chk("ar_valid", {31'd0, if0.valid}, 32'd0);
        chk("ar_busy",  {31'd0, if0.busy}, 32'd0);
        chk("ar_ovr",   {31'd0, if0.overrun}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        if0.continuous = 1'b0;
        in0 = 16'h00FF;
        tick();
        chk("ar_idle_busy", {31'd0, if0.busy}, 32'd0);
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if (j == 31) chk("ar_valid_early", {31'd0, if0.valid}, 32'd0);
            tick();
        end
        chk("ar_new_valid", {31'd0, if0.valid}, 32'd1);
        chk("ar_new_data",  {16'd0, if0.data}, 32'h000000FF);
        chk("ar_new_busy",  {31'd0, if0.busy}, 32'd0);

        // start held every cycle during a single scan
        if0.ready = 1'b1;
        tick();
        if0.ready = 1'b0;
        chk("sp_cleared", {31'd0, if0.valid}, 32'd0);
        in0 = 16'h3C96;
        if0.start = 1'b1;
        tick();
        for (int j = 0; j < 32; j++) begin
            chk("sp_sel", {28'd0, if0.sel}, 32'(j / 2));
            if (j == 31) begin
                chk("sp_valid_early", {31'd0, if0.valid}, 32'd0);
                if0.start = 1'b0;
            end
            tick();
        end
        chk("sp_valid", {31'd0, if0.valid}, 32'd1);
        chk("sp_data",  {16'd0, if0.data}, 32'h00003C96);
        chk("sp_ovr",   {31'd0, if0.overrun}, 32'd0);
        chk("sp_busy",  {31'd0, if0.busy}, 32'd0);
        tick();
        tick();
        chk("sp_no_requeue", {31'd0, if0.busy}, 32'd0);
        chk("sp_sel_idle",   {28'd0, if0.sel}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
